csr_phase_sequencer: RTL and testbench
======================================

Name: csr_phase_sequencer

Overview:
Owns port A of the three CSR RAMs (value, column and row-pointer) and time-shares them between the matrix loader (write-only) and the SpMV multiplier (read-only). A phase FSM sequences IDLE -> LOAD -> SWITCH -> COMPUTE -> DRAIN -> DONE. It issues start pulses to each engine, tracks read latency so it can tag returned data, counts non-zeros written and flags illegal accesses. It replaces the ad-hoc done-based muxing at the top level.

Parameters:
VAL_AW, 14, address width of the value and column RAMs
ROW_AW, 10, address width of the row-pointer RAM
DW, 32, RAM data width
RD_LAT, 1, RAM read latency in cycles, measured from address at the RAM pin to valid dout

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  pulse; begins a load/compute run
abort  in  1  pulse; returns to IDLE from any state
ld_we  in  1  loader write request
ld_sel  in  2  target RAM: 0=val, 1=col, 2=row, 3=illegal
ld_addr  in  VAL_AW  loader address
ld_din  in  DW  loader data
ld_done  in  1  loader finished
ld_start  out  1  one-cycle pulse to the loader
mul_re  in  1  multiplier read request
mul_sel  in  2  target RAM, same encoding as ld_sel
mul_addr  in  VAL_AW  multiplier address
mul_done  in  1  multiplier finished
mul_start  out  1  one-cycle pulse to the multiplier
mul_rvalid  out  1  RAM dout for an accepted read is valid this cycle
mul_rsel  out  2  ld_sel-style tag of the read returning this cycle
ram_we  out  3  write enables {row,col,val}
ram_din  out  DW  write data, shared by all three RAMs
val_addr  out  VAL_AW  value RAM address
col_addr  out  VAL_AW  column RAM address
row_addr  out  ROW_AW  row RAM address
phase  out  3  0=IDLE, 1=LOAD, 2=SWITCH, 3=COMPUTE, 4=DRAIN, 5=DONE
busy  out  1  phase is neither IDLE nor DONE
done  out  1  phase is DONE
err  out  1  sticky illegal-access flag
nnz  out  VAL_AW+1  accepted value-RAM writes in the last load

Behaviour:
- Reset (synchronous, active-high): phase=IDLE. All outputs 0: ram_we, addresses, ram_din, pulses, mul_rvalid/mul_rsel, err, nnz. Read pipeline flushed.
- All RAM-side outputs are registered. An accepted request reaches the RAM pins one cycle later.
- IDLE/DONE, on start:
  - -> LOAD; ld_start=1 for exactly one cycle; nnz cleared; err cleared.
  - start in any other phase is ignored.
- LOAD:
  - ld_we with ld_sel in 0..2 is accepted: the matching ram_we bit is set; its address = ld_addr (row uses ld_addr[ROW_AW-1:0]); ram_din = ld_din.
  - Value writes increment nnz, saturating at 2^VAL_AW.
  - ld_done -> SWITCH. A write in the same cycle as ld_done is still accepted.
- SWITCH: one dead cycle; ram_we=0 and no reads accepted. Then -> COMPUTE with mul_start=1 for one cycle.
- COMPUTE:
  - mul_re with mul_sel in 0..2 is accepted and drives the selected address.
  - ram_we is held 0 throughout COMPUTE.
  - mul_rvalid=1 with mul_rsel=tag exactly RD_LAT+1 cycles after acceptance. Back-to-back reads are allowed every cycle.
  - mul_done -> DRAIN. A read in the same cycle as mul_done is accepted.
- DRAIN: stays until the read pipeline is empty, then -> DONE. DRAIN lasts RD_LAT+1 cycles after the last accepted read.
- DONE: done=1 and RAM addresses hold their last values.
- Illegal-access rules. Each case is dropped (no RAM effect, no rvalid) and sets err:
  - ld_we outside LOAD, or mul_re outside COMPUTE;
  - sel=3;
  - row access with ld_addr/mul_addr[VAL_AW-1:ROW_AW] nonzero.
- ld_done outside LOAD and mul_done outside COMPUTE are ignored silently.
- abort, from any phase: -> IDLE next cycle. ram_we forced 0 that cycle, pipeline flushed (in-flight rvalids suppressed), nnz and err retained.
- abort and start in the same cycle: abort wins.
- reset has priority over abort and over every other input.

Test Plan:
- Reset, start; 3 val, 3 col and 2 row writes; ld_done -> ram_we pulses appear one cycle after each request; nnz=3; phase 1->2->3; mul_start one cycle after SWITCH.
- COMPUTE, RD_LAT=1: mul_re on 4 consecutive cycles (sel 0,1,2,0); mul_done with the last -> mul_rvalid on cycles +2..+5 with tags 0,1,2,0; DONE reached 2 cycles after mul_done.
- ld_we during COMPUTE, mul_re during LOAD, sel=3, and row addr 0x400 -> no ram_we and no rvalid; err=1 sticky until the next start.
- abort two cycles after a mul_re burst -> IDLE next cycle; no mul_rvalid afterwards; ram_we=0.
- 2^14+2 value writes -> nnz saturates at 16384. start while busy ignored; start in DONE -> LOAD, nnz=0.
- reset asserted mid-LOAD together with ld_we -> write dropped; all outputs 0 next cycle; phase=IDLE.

Source files
------------

// File: rtl/csr_phase_sequencer.sv
// csr_phase_sequencer: owns port A of the value, column and row-pointer CSR RAMs.
// The loader gets write access in LOAD and the multiplier gets read access in
// COMPUTE. The block tags returned read data, counts accepted value writes and
// raises a sticky error for every request it has to drop.
//
// Request handshake: ld_we and mul_re have no ready. A request is accepted in
// the cycle it is high if it is legal for the current phase. Nothing is
// stalled or queued, so the requester never has to retry. Accepted requests
// reach the RAM pins on the next cycle. Dropped requests only set err.
module csr_phase_sequencer #(
   parameter int VAL_AW = 14,
   parameter int ROW_AW = 10,
   parameter int DW     = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic              ld_we,
   input  logic [1:0]        ld_sel,
   input  logic [VAL_AW-1:0] ld_addr,
   input  logic [DW-1:0]     ld_din,
   input  logic              ld_done,
   output logic              ld_start,
   input  logic              mul_re,
   input  logic [1:0]        mul_sel,
   input  logic [VAL_AW-1:0] mul_addr,
   input  logic              mul_done,
   output logic              mul_start,
   output logic              mul_rvalid,
   output logic [1:0]        mul_rsel,
   output logic [2:0]        ram_we,
   output logic [DW-1:0]     ram_din,
   output logic [VAL_AW-1:0] val_addr,
   output logic [VAL_AW-1:0] col_addr,
   output logic [ROW_AW-1:0] row_addr,
   output logic [2:0]        phase,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [VAL_AW:0]   nnz
);

   localparam logic [2:0] PH_IDLE    = 3'd0;
   localparam logic [2:0] PH_LOAD    = 3'd1;
   localparam logic [2:0] PH_SWITCH  = 3'd2;
   localparam logic [2:0] PH_COMPUTE = 3'd3;
   localparam logic [2:0] PH_DRAIN   = 3'd4;
   localparam logic [2:0] PH_DONE    = 3'd5;

   localparam logic [VAL_AW:0] NNZ_MAX = {1'b1, {VAL_AW{1'b0}}};

   logic [2:0] state_q;
   logic [2:0] state_d;

   logic ld_legal;
   logic mul_legal;
   logic wr_accept;
   logic wr_illegal;
   logic rd_accept;
   logic rd_illegal;
   logic start_go;
   logic drain_pending;

   // Read pipeline: one stage per cycle between acceptance and valid dout.
   // Stage 0 matches the address at the RAM pin. The last stage is the output.
   logic [RD_LAT:0]      pipe_v;
   logic [RD_LAT:0][1:0] pipe_tag;

   // A row access is legal only if the address fits the smaller row RAM.
   assign ld_legal  = (ld_sel != 2'd3) &&
                      !((ld_sel == 2'd2) && (ld_addr[VAL_AW-1:ROW_AW] != '0));
   assign mul_legal = (mul_sel != 2'd3) &&
                      !((mul_sel == 2'd2) && (mul_addr[VAL_AW-1:ROW_AW] != '0));

   // abort drops everything in its cycle. It neither accepts nor flags requests.
   assign wr_accept  = !abort && ld_we && (state_q == PH_LOAD) && ld_legal;
   assign wr_illegal = !abort && ld_we && !((state_q == PH_LOAD) && ld_legal);
   assign rd_accept  = !abort && mul_re && (state_q == PH_COMPUTE) && mul_legal;
   assign rd_illegal = !abort && mul_re && !((state_q == PH_COMPUTE) && mul_legal);
   assign start_go   = !abort && start &&
                       ((state_q == PH_IDLE) || (state_q == PH_DONE));

   // Check whether any read is still far enough back that its data lands after
   // the next cycle. Stage RD_LAT-1 returns next cycle, which is when DONE
   // begins, so only the earlier stages hold DRAIN.
   always_comb begin
      drain_pending = 1'b0;
      for (int i = 0; i < RD_LAT - 1; i++) begin
         drain_pending = drain_pending | pipe_v[i];
      end
   end

   // Phase state register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= PH_IDLE;
      else       state_q <= state_d;
   end

   // Next-phase logic. abort overrides every other transition.
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = PH_IDLE;
      end else begin
         case (state_q)
            PH_IDLE, PH_DONE: if (start)          state_d = PH_LOAD;
            PH_LOAD:          if (ld_done)        state_d = PH_SWITCH;
            PH_SWITCH:                            state_d = PH_COMPUTE;
            PH_COMPUTE:       if (mul_done)       state_d = PH_DRAIN;
            PH_DRAIN:         if (!drain_pending) state_d = PH_DONE;
            default:                              state_d = PH_IDLE;
         endcase
      end
   end

   // Phase-derived status outputs. The raw state is visible on phase.
   always_comb begin
      phase = state_q;
      busy  = (state_q != PH_IDLE) && (state_q != PH_DONE);
      done  = (state_q == PH_DONE);
   end

   // Registered RAM port, engine start pulses, write count and error flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         ram_we    <= '0;
         ram_din   <= '0;
         val_addr  <= '0;
         col_addr  <= '0;
         row_addr  <= '0;
         ld_start  <= 1'b0;
         mul_start <= 1'b0;
         err       <= 1'b0;
         nnz       <= '0;
      end else begin
         ram_we    <= '0;
         ld_start  <= start_go;
         mul_start <= (state_q == PH_SWITCH) && !abort;
         if (wr_accept) begin
            ram_din <= ld_din;
            case (ld_sel)
               2'd0: begin
                  ram_we   <= 3'b001;
                  val_addr <= ld_addr;
               end
               2'd1: begin
                  ram_we   <= 3'b010;
                  col_addr <= ld_addr;
               end
               2'd2: begin
                  ram_we   <= 3'b100;
                  row_addr <= ld_addr[ROW_AW-1:0];
               end
               default: ;
            endcase
         end
         if (rd_accept) begin
            case (mul_sel)
               2'd0:    val_addr <= mul_addr;
               2'd1:    col_addr <= mul_addr;
               2'd2:    row_addr <= mul_addr[ROW_AW-1:0];
               default: ;
            endcase
         end
         if (start_go) begin
            nnz <= '0;
         end else if (wr_accept && (ld_sel == 2'd0) && (nnz != NNZ_MAX)) begin
            nnz <= nnz + 1'b1;
         end
         if (start_go) begin
            err <= 1'b0;
         end else if (wr_illegal || rd_illegal) begin
            err <= 1'b1;
         end
      end
   end

   // Shift the valid and tag of each accepted read toward the dout-valid slot.
   // abort and reset clear the reads that are still in flight.
   always_ff @(posedge clk) begin
      if (reset || abort) begin
         pipe_v   <= '0;
         pipe_tag <= '0;
      end else begin
         pipe_v   <= {pipe_v[RD_LAT-1:0], rd_accept};
         pipe_tag <= {pipe_tag[RD_LAT-1:0], (rd_accept ? mul_sel : 2'b00)};
      end
   end

   assign mul_rvalid = pipe_v[RD_LAT];
   assign mul_rsel   = pipe_tag[RD_LAT];

endmodule

// File: tb/tb_csr_phase_sequencer.sv
// Bench for csr_phase_sequencer. It applies a table of hand-computed vectors,
// then hand-written saturation and start-ignore sequences, then random traffic.
// A behavioural model runs alongside every cycle and checks all outputs.
module tb_csr_phase_sequencer;

   localparam int VAL_AW = 14;
   localparam int ROW_AW = 10;
   localparam int DW     = 32;
   localparam int RD_LAT = 1;

   // ---------------- clock / reset / DUT ----------------
   logic              clk;
   logic              reset;
   logic              start;
   logic              abort;
   logic              ld_we;
   logic [1:0]        ld_sel;
   logic [VAL_AW-1:0] ld_addr;
   logic [DW-1:0]     ld_din;
   logic              ld_done;
   logic              ld_start;
   logic              mul_re;
   logic [1:0]        mul_sel;
   logic [VAL_AW-1:0] mul_addr;
   logic              mul_done;
   logic              mul_start;
   logic              mul_rvalid;
   logic [1:0]        mul_rsel;
   logic [2:0]        ram_we;
   logic [DW-1:0]     ram_din;
   logic [VAL_AW-1:0] val_addr;
   logic [VAL_AW-1:0] col_addr;
   logic [ROW_AW-1:0] row_addr;
   logic [2:0]        phase;
   logic              busy;
   logic              done;
   logic              err;
   logic [VAL_AW:0]   nnz;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   csr_phase_sequencer #(
      .VAL_AW(VAL_AW), .ROW_AW(ROW_AW), .DW(DW), .RD_LAT(RD_LAT)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .ld_we(ld_we), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_din(ld_din),
      .ld_done(ld_done), .ld_start(ld_start),
      .mul_re(mul_re), .mul_sel(mul_sel), .mul_addr(mul_addr),
      .mul_done(mul_done), .mul_start(mul_start),
      .mul_rvalid(mul_rvalid), .mul_rsel(mul_rsel),
      .ram_we(ram_we), .ram_din(ram_din),
      .val_addr(val_addr), .col_addr(col_addr), .row_addr(row_addr),
      .phase(phase), .busy(busy), .done(done), .err(err), .nnz(nnz)
   );

   // ---------------- scoreboard counters ----------------
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Phases use the numbering of the phase output. Each accepted read is stored
   // in exp_q with the absolute cycle its data is due.
   typedef struct {
      int         due;
      logic [1:0] tag;
   } rd_t;
   rd_t exp_q[$];

   int              m_cyc = 0;
   int              m_phase = 0;
   int              m_nnz = 0;
   logic            m_err = 1'b0;
   logic [2:0]      m_we = '0;
   logic [DW-1:0]   m_din = '0;
   logic [VAL_AW-1:0] m_val_addr = '0;
   logic [VAL_AW-1:0] m_col_addr = '0;
   logic [ROW_AW-1:0] m_row_addr = '0;
   logic            m_ld_start = 1'b0;
   logic            m_mul_start = 1'b0;
   logic            m_rvalid = 1'b0;
   logic [1:0]      m_rsel = '0;

   task automatic model_step();
      int  nxt;
      bit  ld_ok;
      bit  rd_ok;
      bit  all_out;
      nxt = m_cyc + 1;
      if (reset) begin
         m_phase = 0; m_nnz = 0; m_err = 0; m_we = '0; m_din = '0;
         m_val_addr = '0; m_col_addr = '0; m_row_addr = '0;
         m_ld_start = 0; m_mul_start = 0; m_rvalid = 0; m_rsel = '0;
         exp_q.delete();
      end else if (abort) begin
         m_phase = 0; m_we = '0; m_ld_start = 0; m_mul_start = 0;
         m_rvalid = 0; m_rsel = '0;
         exp_q.delete();
      end else begin
         m_we = '0; m_ld_start = 0; m_mul_start = 0;
         ld_ok = ld_we && (m_phase == 1) && (ld_sel != 3) &&
                 !((ld_sel == 2) && (int'(ld_addr) >= (1 << ROW_AW)));
         rd_ok = mul_re && (m_phase == 3) && (mul_sel != 3) &&
                 !((mul_sel == 2) && (int'(mul_addr) >= (1 << ROW_AW)));
         if (ld_we && !ld_ok) m_err = 1;
         if (mul_re && !rd_ok) m_err = 1;
         if (ld_ok) begin
            m_din = ld_din;
            case (ld_sel)
               2'd0: begin m_we = 3'b001; m_val_addr = ld_addr; end
               2'd1: begin m_we = 3'b010; m_col_addr = ld_addr; end
               default: begin m_we = 3'b100; m_row_addr = ld_addr[ROW_AW-1:0]; end
            endcase
            if (ld_sel == 0 && m_nnz < (1 << VAL_AW)) m_nnz++;
         end
         m_rvalid = 0; m_rsel = '0;
         if (exp_q.size() > 0 && exp_q[0].due == nxt) begin
            m_rvalid = 1; m_rsel = exp_q[0].tag;
            void'(exp_q.pop_front());
         end
         if (rd_ok) begin
            case (mul_sel)
               2'd0: m_val_addr = mul_addr;
               2'd1: m_col_addr = mul_addr;
               default: m_row_addr = mul_addr[ROW_AW-1:0];
            endcase
            exp_q.push_back('{due: nxt + RD_LAT, tag: mul_sel});
         end
         case (m_phase)
            0, 5: if (start) begin
               m_phase = 1; m_ld_start = 1; m_nnz = 0; m_err = 0;
            end
            1: if (ld_done) m_phase = 2;
            2: begin m_phase = 3; m_mul_start = 1; end
            3: if (mul_done) m_phase = 4;
            4: begin
               all_out = 1;
               foreach (exp_q[i]) if (exp_q[i].due > nxt) all_out = 0;
               if (all_out) m_phase = 5;
            end
            default: m_phase = 0;
         endcase
      end
      m_cyc = nxt;
   endtask

   task automatic compare_all();
      chk("phase", 32'(phase), 32'(m_phase));
      chk("busy", 32'(busy), 32'(m_phase != 0 && m_phase != 5));
      chk("done", 32'(done), 32'(m_phase == 5));
      chk("ram_we", 32'(ram_we), 32'(m_we));
      chk("ram_din", 32'(ram_din), 32'(m_din));
      chk("val_addr", 32'(val_addr), 32'(m_val_addr));
      chk("col_addr", 32'(col_addr), 32'(m_col_addr));
      chk("row_addr", 32'(row_addr), 32'(m_row_addr));
      chk("ld_start", 32'(ld_start), 32'(m_ld_start));
      chk("mul_start", 32'(mul_start), 32'(m_mul_start));
      chk("mul_rvalid", 32'(mul_rvalid), 32'(m_rvalid));
      chk("mul_rsel", 32'(mul_rsel), 32'(m_rsel));
      chk("err", 32'(err), 32'(m_err));
      chk("nnz", 32'(nnz), 32'(m_nnz));
   endtask

   // ---------------- driver tasks ----------------
   task automatic clear_inputs();
      reset = 0; start = 0; abort = 0;
      ld_we = 0; ld_sel = '0; ld_addr = '0; ld_din = '0; ld_done = 0;
      mul_re = 0; mul_sel = '0; mul_addr = '0; mul_done = 0;
   endtask

   // The model advances on the current inputs. The DUT is then clocked and
   // its outputs are sampled 1 time unit after the edge.
   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic rand_inputs();
      reset    = ($urandom_range(0, 499) == 0);
      abort    = ($urandom_range(0, 99) == 0);
      start    = ($urandom_range(0, 14) == 0);
      ld_we    = ($urandom_range(0, 1) == 1);
      ld_sel   = 2'($urandom_range(0, 3));
      ld_addr  = ($urandom_range(0, 5) == 0) ? VAL_AW'($urandom) : VAL_AW'($urandom_range(0, 1023));
      ld_din   = $urandom;
      ld_done  = ($urandom_range(0, 24) == 0);
      mul_re   = ($urandom_range(0, 2) != 0);
      mul_sel  = 2'($urandom_range(0, 3));
      mul_addr = ($urandom_range(0, 5) == 0) ? VAL_AW'($urandom) : VAL_AW'($urandom_range(0, 1023));
      mul_done = ($urandom_range(0, 24) == 0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic rst, st, ab, we;
      logic [1:0] lsel;
      logic [VAL_AW-1:0] laddr;
      logic [DW-1:0] ldin;
      logic ldone, re;
      logic [1:0] msel;
      logic [VAL_AW-1:0] maddr;
      logic mdone;
      logic [2:0] e_phase, e_we;
      logic e_ls, e_ms, e_rv;
      logic [1:0] e_rs;
      logic e_err;
      logic [VAL_AW:0] e_nnz;
   } vec_t;
   vec_t vecs[$];

   function automatic vec_t mk(
      input logic rst, st, ab, we, input logic [1:0] lsel, input int laddr, input int ldin,
      input logic ldone, re, input logic [1:0] msel, input int maddr, input logic mdone,
      input int e_phase, e_we, input logic e_ls, e_ms, e_rv, input int e_rs,
      input logic e_err, input int e_nnz);
      vec_t v;
      v.rst = rst; v.st = st; v.ab = ab; v.we = we; v.lsel = lsel;
      v.laddr = VAL_AW'(laddr); v.ldin = DW'(ldin); v.ldone = ldone;
      v.re = re; v.msel = msel; v.maddr = VAL_AW'(maddr); v.mdone = mdone;
      v.e_phase = 3'(e_phase); v.e_we = 3'(e_we); v.e_ls = e_ls; v.e_ms = e_ms;
      v.e_rv = e_rv; v.e_rs = 2'(e_rs); v.e_err = e_err; v.e_nnz = (VAL_AW+1)'(e_nnz);
      return v;
   endfunction

   initial begin
      clear_inputs();
      //            rst st ab we sel addr    din    ldn re sel maddr  mdn  ph we  ls ms rv rs er nnz
      vecs.push_back(mk(1, 0, 0, 0, 0, 0,      0,     0,  0, 0, 0,     0,   0, 0,  0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0,      0,     0,  0, 0, 0,     0,   1, 0,  1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 5,      'h11,  0,  0, 0, 0,     0,   1, 1,  0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 1, 0, 6,      'h22,  0,  0, 0, 0,     0,   1, 1,  0, 0, 0, 0, 0, 2));
      vecs.push_back(mk(0, 0, 0, 1, 1, 5,      'h33,  0,  0, 0, 0,     0,   1, 2,  0, 0, 0, 0, 0, 2));
      vecs.push_back(mk(0, 0, 0, 1, 1, 6,      'h44,  0,  0, 0, 0,     0,   1, 2,  0, 0, 0, 0, 0, 2));
      vecs.push_back(mk(0, 0, 0, 1, 2, 3,      'h55,  0,  0, 0, 0,     0,   1, 4,  0, 0, 0, 0, 0, 2));
      vecs.push_back(mk(0, 0, 0, 1, 1, 7,      'h66,  0,  0, 0, 0,     0,   1, 2,  0, 0, 0, 0, 0, 2));
      vecs.push_back(mk(0, 0, 0, 1, 2, 'h3ff,  'h77,  0,  0, 0, 0,     0,   1, 4,  0, 0, 0, 0, 0, 2));
      vecs.push_back(mk(0, 0, 0, 1, 0, 7,      'h88,  1,  0, 0, 0,     0,   2, 1,  0, 0, 0, 0, 0, 3));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0,      0,     0,  0, 0, 0,     0,   3, 0,  0, 1, 0, 0, 0, 3));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0,      0,     0,  1, 0, 5,     0,   3, 0,  0, 0, 0, 0, 0, 3));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0,      0,     0,  1, 1, 6,     0,   3, 0,  0, 0, 1, 0, 0, 3));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0,      0,     0,  1, 2, 3,     0,   3, 0,  0, 0, 1, 1, 0, 3));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0,      0,     0,  1, 0, 7,     1,   4, 0,  0, 0, 1, 2, 0, 3));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0,      0,     0,  0, 0, 0,     0,   5, 0,  0, 0, 1, 0, 0, 3));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0,      0,     0,  0, 0, 0,     0,   5, 0,  0, 0, 0, 0, 0, 3));
      vecs.push_back(mk(0, 0, 0, 1, 0, 1,      'h99,  0,  0, 0, 0,     0,   5, 0,  0, 0, 0, 0, 1, 3));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0,      0,     0,  0, 0, 0,     0,   1, 0,  1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0,      0,     0,  1, 0, 2,     0,   1, 0,  0, 0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 1, 3, 2,      'haa,  0,  0, 0, 0,     0,   1, 0,  0, 0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 1, 2, 'h400,  'hbb,  0,  0, 0, 0,     0,   1, 0,  0, 0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0,      0,     1,  0, 0, 0,     0,   2, 0,  0, 0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0,      0,     0,  0, 0, 0,     0,   3, 0,  0, 1, 0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 2,      'hcc,  0,  0, 0, 0,     0,   3, 0,  0, 0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0,      0,     0,  1, 3, 4,     0,   3, 0,  0, 0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0,      0,     0,  1, 2, 'h400, 0,   3, 0,  0, 0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0,      0,     0,  1, 0, 9,     0,   3, 0,  0, 0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0,      0,     0,  1, 1, 10,    0,   3, 0,  0, 0, 1, 0, 1, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0, 0,      0,     0,  0, 0, 0,     0,   0, 0,  0, 0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0,      0,     0,  0, 0, 0,     0,   0, 0,  0, 0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0,      0,     0,  0, 0, 0,     0,   1, 0,  1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1, 0, 1,      'hdd,  0,  0, 0, 0,     0,   0, 0,  0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 0, 0, 0,      0,     0,  0, 0, 0,     0,   0, 0,  0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0,      0,     0,  0, 0, 0,     0,   1, 0,  1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 4,      'hee,  0,  0, 0, 0,     0,   1, 1,  0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(1, 0, 0, 1, 1, 4,      'hff,  0,  0, 0, 0,     0,   0, 0,  0, 0, 0, 0, 0, 0));

      // ---------------- table-driven vectors ----------------
      foreach (vecs[i]) begin
         reset = vecs[i].rst; start = vecs[i].st; abort = vecs[i].ab;
         ld_we = vecs[i].we; ld_sel = vecs[i].lsel; ld_addr = vecs[i].laddr;
         ld_din = vecs[i].ldin; ld_done = vecs[i].ldone;
         mul_re = vecs[i].re; mul_sel = vecs[i].msel; mul_addr = vecs[i].maddr;
         mul_done = vecs[i].mdone;
         step();
         chk($sformatf("v%0d_phase", i), 32'(phase), 32'(vecs[i].e_phase));
         chk($sformatf("v%0d_ram_we", i), 32'(ram_we), 32'(vecs[i].e_we));
         chk($sformatf("v%0d_ld_start", i), 32'(ld_start), 32'(vecs[i].e_ls));
         chk($sformatf("v%0d_mul_start", i), 32'(mul_start), 32'(vecs[i].e_ms));
         chk($sformatf("v%0d_rvalid", i), 32'(mul_rvalid), 32'(vecs[i].e_rv));
         chk($sformatf("v%0d_rsel", i), 32'(mul_rsel), 32'(vecs[i].e_rs));
         chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].e_err));
         chk($sformatf("v%0d_nnz", i), 32'(nnz), 32'(vecs[i].e_nnz));
         if (vecs[i].rst) begin
            chk($sformatf("v%0d_rst_din", i), ram_din, 32'd0);
            chk($sformatf("v%0d_rst_addr", i), 32'(val_addr) | 32'(col_addr) | 32'(row_addr), 32'd0);
         end
      end
      clear_inputs();

      // ---------------- nnz saturation, start ignored while busy ----------------
      start = 1; step(); clear_inputs();
      for (int i = 0; i < (1 << VAL_AW) + 2; i++) begin
         ld_we = 1; ld_sel = 2'd0; ld_addr = VAL_AW'($urandom); ld_din = $urandom;
         start = (i == 100);
         step();
         if (i == 100) chk("busy_start_ignored", 32'(ld_start), 32'd0);
      end
      clear_inputs();
      ld_done = 1; step(); clear_inputs();
      chk("sat_nnz", 32'(nnz), 32'd16384);
      step();
      chk("sat_mul_start", 32'(mul_start), 32'd1);
      mul_done = 1; step(); clear_inputs();
      step();
      chk("sat_done_phase", 32'(phase), 32'd5);
      chk("sat_done_flag", 32'(done), 32'd1);
      start = 1; step(); clear_inputs();
      chk("restart_phase", 32'(phase), 32'd1);
      chk("restart_nnz", 32'(nnz), 32'd0);

      // ---------------- randomized traffic against the model ----------------
      for (int i = 0; i < 4000; i++) begin
         rand_inputs();
         step();
      end
      clear_inputs();
      step();

      // ---------------- report ----------------
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
